// File: rtl/int_to_fp_pipe_vec_pkg.sv
// Shared FPU definitions: rounding modes, op/flag bit positions, FP32 bias
// and the per-lane prenormalised operand that crosses the pipeline.
package int_to_fp_pipe_vec_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  localparam int OP_NCVT   = 2;  // 1: non-convert op, all lanes produce 0
  localparam int OP_SRC64  = 1;  // 1: 64-bit source, 0: low 32 bits only
  localparam int OP_SIGNED = 0;  // 1: two's complement source

  localparam int FLG_NV = 4;
  localparam int FLG_DZ = 3;
  localparam int FLG_OF = 2;
  localparam int FLG_UF = 1;
  localparam int FLG_NX = 0;

  localparam int FP32_BIAS = 127;

  // Stage-1 operand: magnitude, sign, zero and leading-zero count.
  typedef struct packed {
    logic [63:0] mag;
    logic        sgn;
    logic        zero;
    logic [5:0]  lzc;
  } norm_t;

endpackage

// File: rtl/int_to_fp_lane.sv
// One conversion lane. The prenorm half feeds pipeline stage 1; the postnorm
// half reads the last retimed copy and produces the FP32 result and flags.
module int_to_fp_lane
  import int_to_fp_pipe_vec_pkg::*;
(
  input  logic [63:0] a,
  input  logic        src64,
  input  logic        sgn_src,
  output norm_t       pre,
  input  norm_t       post,
  input  logic [2:0]  rm,
  input  logic        en,
  output logic [31:0] res,
  output logic [4:0]  flg
);

  logic [63:0] src, mag;
  logic        neg;
  logic [5:0]  lzc;

  // Prenorm: extend the source, take magnitude, count leading zeros.
  always_comb begin
    src = src64 ? a : (sgn_src ? {{32{a[31]}}, a[31:0]} : {32'b0, a[31:0]});
    neg = sgn_src & src[63];
    mag = neg ? (~src + 64'd1) : src;
    lzc = '0;
    for (int i = 0; i < 64; i++)
      if (mag[i]) lzc = 6'(63 - i);
    pre = '{mag: mag, sgn: neg, zero: (src == '0), lzc: lzc};
  end

  logic [63:0] norm;
  logic        grd, stk, inx, rup;
  logic [24:0] sig;
  logic [7:0]  ex;

  // Postnorm: left-justify, round the 24-bit significand, fold carry into exponent.
  always_comb begin
    norm = post.mag << post.lzc;
    grd  = norm[39];
    stk  = |norm[38:0];
    inx  = grd | stk;
    case (rm)
      RM_RTZ:  rup = 1'b0;
      RM_RDN:  rup = inx & post.sgn;
      RM_RUP:  rup = inx & ~post.sgn;
      RM_RMM:  rup = grd;
      default: rup = grd & (stk | norm[40]);  // RNE, also encodings 5..7
    endcase
    sig = {1'b0, norm[63:40]} + 25'(rup);
    ex  = 8'(FP32_BIAS + 63) - {2'b00, post.lzc} + {7'b0, sig[24]};
    res = {post.sgn, ex, sig[24] ? sig[23:1] : sig[22:0]};
    flg = '0;
    // Integer to FP32 can never be invalid, divide, overflow or underflow.
    flg[FLG_NV] = 1'b0; flg[FLG_DZ] = 1'b0; flg[FLG_OF] = 1'b0; flg[FLG_UF] = 1'b0;
    flg[FLG_NX] = inx;
    if (!en || post.zero) begin
      res = '0;
      flg = '0;
    end
  end

endmodule

// File: rtl/int_to_fp_pipe_vec.sv
// Vector integer-to-FP32 converter with a STAGES-deep elastic pipeline.
// Stage 1 holds prenormalised operands, middle stages are retiming copies,
// the last stage holds the rounded results.
module int_to_fp_pipe_vec
  import int_to_fp_pipe_vec_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int STAGES    = 2,
  parameter int CTRL_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [2:0]                 op_i,
  input  logic [2:0]                 rm_i,
  input  logic [NUM_LANES-1:0][63:0] a_i,
  input  logic [NUM_LANES-1:0]       mask_i,
  input  logic [CTRL_W-1:0]          ctrl_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [NUM_LANES-1:0][31:0] result_o,
  output logic [NUM_LANES-1:0][4:0]  fflags_o,
  output logic [4:0]                 fflags_or_o,
  output logic [CTRL_W-1:0]          ctrl_o
);

  localparam int MID = STAGES - 1;  // last stage holding prenorm data

  logic [STAGES:1]             vld_pipe, go;
  norm_t [NUM_LANES-1:0]       pre_n;
  norm_t [NUM_LANES-1:0]       nrm_q  [1:MID];
  logic [2:0]                  rm_q   [1:MID];
  logic [NUM_LANES-1:0]        en_q   [1:MID];
  logic [CTRL_W-1:0]           ctrl_q [1:MID];
  logic [NUM_LANES-1:0][31:0]  res_n, res_q;
  logic [NUM_LANES-1:0][4:0]   flg_n, flg_q;
  logic [CTRL_W-1:0]           ctrl_oq;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    int_to_fp_lane u_lane (
      .a       (a_i[k]),
      .src64   (op_i[OP_SRC64]),
      .sgn_src (op_i[OP_SIGNED]),
      .pre     (pre_n[k]),
      .post    (nrm_q[MID][k]),
      .rm      (rm_q[MID]),
      .en      (en_q[MID][k]),
      .res     (res_n[k]),
      .flg     (flg_n[k])
    );
  end

  // Stage k may load when it is empty or its contents move on this edge.
  always_comb begin
    go = '0;
    go[STAGES] = ~vld_pipe[STAGES] | out_ready_i;
    for (int k = STAGES - 1; k >= 1; k--)
      go[k] = ~vld_pipe[k] | go[k+1];
  end

  // A flushed cycle swallows the offered op, so it can always be "accepted".
  assign in_ready_o  = go[1] | flush_i;
  assign out_valid_o = vld_pipe[STAGES] & ~flush_i;
  assign result_o    = res_q;
  assign fflags_o    = flg_q;
  assign ctrl_o      = ctrl_oq;

  // Disabled lanes already carry zero flags, so a plain OR covers enabled lanes.
  always_comb begin
    fflags_or_o = '0;
    for (int k = 0; k < NUM_LANES; k++) fflags_or_o |= flg_q[k];
  end

  // Valid shift register plus per-stage data; data only moves with a valid op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      for (int s = 1; s <= MID; s++) begin
        nrm_q[s]  <= '0;
        rm_q[s]   <= '0;
        en_q[s]   <= '0;
        ctrl_q[s] <= '0;
      end
      res_q   <= '0;
      flg_q   <= '0;
      ctrl_oq <= '0;
    end else begin
      if (flush_i) begin
        vld_pipe <= '0;
      end else begin
        for (int s = STAGES; s >= 2; s--)
          if (go[s]) vld_pipe[s] <= vld_pipe[s-1];
        if (go[1]) vld_pipe[1] <= in_valid_i;
      end
      if (go[1] && in_valid_i) begin
        nrm_q[1]  <= pre_n;
        rm_q[1]   <= rm_i;
        en_q[1]   <= mask_i & {NUM_LANES{~op_i[OP_NCVT]}};
        ctrl_q[1] <= ctrl_i;
      end
      for (int s = 2; s <= MID; s++)
        if (go[s] && vld_pipe[s-1]) begin
          nrm_q[s]  <= nrm_q[s-1];
          rm_q[s]   <= rm_q[s-1];
          en_q[s]   <= en_q[s-1];
          ctrl_q[s] <= ctrl_q[s-1];
        end
      if (go[STAGES] && vld_pipe[MID]) begin
        res_q   <= res_n;
        flg_q   <= flg_n;
        ctrl_oq <= ctrl_q[MID];
      end
    end
  end

endmodule

// File: doc/int_to_fp_pipe_vec.md
INT_TO_FP_PIPE_VEC -- requirements
Module: int_to_fp_pipe_vec

Interface
REQ-001 Parameter NUM_LANES, default 4, number of independent conversion lanes (1..32).
REQ-002 Parameter STAGES, default 2, pipeline depth in register stages (2..4).
REQ-003 Parameter CTRL_W, default 8, width of opaque sideband tag carried with each operation.
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 flush_i  input  1  synchronous kill of all in-flight operations.
REQ-007 in_valid_i  input  1  operation offered.
REQ-008 in_ready_o  output  1  operation accepted when in_valid_i && in_ready_o.
REQ-009 op_i  input  3  op[2]=0 convert, op[2]=1 non-convert; op[1] 64-bit source; op[0] signed source.
REQ-010 rm_i  input  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM.
REQ-011 a_i  input  64*NUM_LANES  integer source per lane; lane k at bits [64k+63:64k].
REQ-012 mask_i  input  NUM_LANES  lane enable.
REQ-013 ctrl_i  input  CTRL_W  sideband tag.
REQ-014 out_valid_o  output  1  result available.
REQ-015 out_ready_i  input  1  consumer accepts result.
REQ-016 result_o  output  32*NUM_LANES  FP32 result per lane.
REQ-017 fflags_o  output  5*NUM_LANES  per-lane flags {NV,DZ,OF,UF,NX}.
REQ-018 fflags_or_o  output  5  bitwise OR of fflags over enabled lanes.
REQ-019 ctrl_o  output  CTRL_W  tag of the operation presented on out_valid_o.

Function
REQ-020 A 32-bit source (op[1]=0) SHALL use a_i lane bits [31:0] only, sign- or zero-extended per op[0].
REQ-021 Result SHALL be the IEEE-754 binary32 value of the source, rounded per rm; zero source gives +0.0 with no flags.
REQ-022 NX SHALL be set iff rounding discarded nonzero bits; NV, DZ, OF, UF SHALL always be 0.
REQ-023 rm values 5..7 SHALL be treated as RNE.
REQ-024 Masked-off lanes, and all lanes when op[2]=1, SHALL output result 0 and flags 0.
REQ-025 Stage 1 SHALL register absolute value, sign, zero flag and leading-zero count (6 bits); the final stage SHALL register rounded result and flags; stages between are retiming registers.
REQ-026 Latency SHALL be exactly STAGES cycles from acceptance to out_valid_o when out_ready_i stays high.
REQ-027 Stage k SHALL advance when its successor is empty or advancing; the last stage advances when out_ready_i=1.
REQ-028 in_ready_o SHALL equal (stage 1 empty or advancing) and SHALL depend combinationally on out_ready_i.
REQ-029 Throughput SHALL be one operation per cycle with no bubbles under continuous out_ready_i=1.
REQ-030 When out_valid_o=1 && out_ready_i=0, result_o, fflags_o, fflags_or_o, ctrl_o SHALL hold stable.
REQ-031 With all stages full and out_ready_i=0, in_ready_o SHALL be 0; no operation is lost or duplicated.
REQ-032 ctrl_i, op and mask SHALL travel with their operation and emerge unchanged on ctrl_o.
REQ-033 flush_i=1 SHALL clear every stage valid at the next edge, force out_valid_o=0 in the flush cycle, and drop any operation offered in that cycle.

Reset
REQ-034 rst_n low SHALL clear all stage valids; out_valid_o, result_o, fflags_o, fflags_or_o, ctrl_o SHALL read 0.
REQ-035 Reset asserted mid-operation SHALL discard all in-flight operations; first acceptance possible on the first edge after deassertion.
REQ-036 Datapath registers need reset only to 0; no other state exists.

Structure
REQ-037 Rounding-mode encodings, op bit positions, fflags bit positions and FP32 exponent bias (127) SHALL live in the shared FPU package.
REQ-038 Per-lane combinational logic SHALL be one sub-module int_to_fp_lane (prenorm and postnorm halves), instantiated NUM_LANES times; pipeline control stays in the top.

Verification
REQ-039 Signed int32 -1, RNE, mask 1 -> 0xBF800000, flags 0, after exactly STAGES cycles.
REQ-040 Unsigned int32 0xFFFFFFFF: RNE -> 0x4F800000 NX=1; RTZ -> 0x4F7FFFFF NX=1.
REQ-041 Signed int64 0x8000000000000000, RUP -> 0xDF000000, flags 0; source 0 -> 0x00000000 flags 0.
REQ-042 Four-lane op, mask 4'b0101, op[2]=1 then op[2]=0 -> masked lanes and non-convert op read 0; fflags_or_o covers lanes 0 and 2 only.
REQ-043 Back-to-back stream of 20 ops with out_ready_i random 50% -> every ctrl tag emerges once, in order, outputs stable while stalled.
REQ-044 Pipeline full, out_ready_i=0, then flush_i one cycle with in_valid_i=1 -> in_ready_o=1 in flush cycle, out_valid_o=0 until a new op completes STAGES cycles later.
